// File: rtl/ir_packet_decoder.sv
// IR link receive decoder: demodulated envelope -> 4-bit drive command {fwd,back,left,right}.
// Optional IR_RX_CARSEL_CHECK_EN: accept only a select burst in SEL_MIN..SEL_MAX (this car's code).
module ir_packet_decoder #(
  parameter int         TICK_DIV  = 2776,
  parameter logic [7:0] START_MIN = 8'd160,
  parameter logic [7:0] START_MAX = 8'd220,
  parameter logic [7:0] SEL_MIN   = 8'd38,
  parameter logic [7:0] SEL_MAX   = 8'd56,
  parameter logic [7:0] ONE_MIN   = 8'd38,
  parameter logic [7:0] ONE_MAX   = 8'd56,
  parameter logic [7:0] ZERO_MIN  = 8'd16,
  parameter logic [7:0] ZERO_MAX  = 8'd30,
  parameter logic [7:0] GAP_MIN   = 8'd15,
  parameter logic [7:0] GAP_MAX   = 8'd35
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  output logic [3:0] COMMAND,
  output logic       CMD_VALID,
  output logic       PKT_ERROR
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_BITS} state_t;

  logic          ir_meta_q, ir_s_q, ir_prev_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]    len_q, len_d;
  state_t        state_q;
  logic [1:0]    idx_q;
  logic [3:0]    shreg_q;
  logic [3:0]    command_q;
  logic          cmd_valid_q, pkt_error_q;

  logic tick, edge_w, rise_w, fall_w;
  logic start_ok, sel_ok, one_ok, zero_ok, gap_ok, timeout_w;

  assign tick   = (tick_cnt_q == TICK_LAST);
  assign edge_w = ir_s_q ^ ir_prev_q;
  assign rise_w = ir_s_q & ~ir_prev_q;
  assign fall_w = ~ir_s_q & ir_prev_q;

  assign start_ok = (len_q >= START_MIN) && (len_q <= START_MAX);
  assign one_ok   = (len_q >= ONE_MIN)   && (len_q <= ONE_MAX);
  assign zero_ok  = (len_q >= ZERO_MIN)  && (len_q <= ZERO_MAX);
  assign gap_ok   = (len_q >= GAP_MIN)   && (len_q <= GAP_MAX);
`ifdef IR_RX_CARSEL_CHECK_EN
  assign sel_ok   = (len_q >= SEL_MIN) && (len_q <= SEL_MAX);
`else
  assign sel_ok   = (len_q >= ZERO_MIN) && (len_q < START_MIN);
`endif
  // The level in progress has already outlasted anything legal.
  assign timeout_w = ir_s_q ? (len_q > START_MAX) : (len_q > GAP_MAX);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    len_d      = len_q;
    if (edge_w)
      len_d = 8'd0;
    else if (tick && (len_q != 8'hFF))
      len_d = len_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_meta_q   <= 1'b0;
      ir_s_q      <= 1'b0;
      ir_prev_q   <= 1'b0;
      tick_cnt_q  <= '0;
      len_q       <= 8'd0;
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      shreg_q     <= 4'd0;
      command_q   <= 4'd0;
      cmd_valid_q <= 1'b0;
      pkt_error_q <= 1'b0;
    end else begin
      ir_meta_q   <= IR_IN;
      ir_s_q      <= ir_meta_q;
      ir_prev_q   <= ir_s_q;
      tick_cnt_q  <= tick_cnt_d;
      len_q       <= len_d;
      cmd_valid_q <= 1'b0;
      pkt_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fall_w && start_ok) begin
            state_q <= ST_SELECT;
            idx_q   <= 2'd0;
            shreg_q <= 4'd0;
          end
        end
        ST_SELECT: begin
          if ((rise_w && !gap_ok) || (fall_w && !sel_ok) || (!edge_w && timeout_w)) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            shreg_q     <= 4'd0;
            pkt_error_q <= 1'b1;
          end else if (fall_w) begin
            state_q <= ST_BITS;
            idx_q   <= 2'd0;
          end
        end
        ST_BITS: begin
          if ((rise_w && !gap_ok) || (fall_w && !one_ok && !zero_ok) ||
              (!edge_w && timeout_w)) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            shreg_q     <= 4'd0;
            pkt_error_q <= 1'b1;
          end else if (fall_w) begin
            // Bit 3 completes the command immediately; the trailing gap is not awaited.
            if (idx_q == 2'd3) begin
              command_q   <= {one_ok, shreg_q[2:0]};
              cmd_valid_q <= 1'b1;
              state_q     <= ST_IDLE;
              idx_q       <= 2'd0;
              shreg_q     <= 4'd0;
            end else begin
              shreg_q[idx_q] <= one_ok;
              idx_q          <= idx_q + 2'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= 2'd0;
          shreg_q <= 4'd0;
        end
      endcase
    end
  end

  assign COMMAND   = command_q;
  assign CMD_VALID = cmd_valid_q;
  assign PKT_ERROR = pkt_error_q;

endmodule
